// File: rtl/cla_pkg.sv
// Shared definitions for the carry-lookahead subtract pipeline.
// Latency: n/a (types, constants and a pure helper function).
// Backpressure: n/a.
package cla_pkg;

  // Bits handled by one CLA slice, which is also one pipeline stage.
  localparam int SLICE_W = 4;

  typedef logic [SLICE_W-1:0] slice_t;

  // Two's-complement overflow of a + ~b + cin: the addends share a sign and the
  // result's sign differs from it. With ~b as the second addend this is the
  // "sign(a) != sign(b) and sign(diff) != sign(a)" rule for subtraction.
  function automatic logic sub_ovf(input logic a_msb, input logic nb_msb, input logic d_msb);
    return (a_msb ~^ nb_msb) & (d_msb ^ a_msb);
  endfunction

endpackage

// File: rtl/cla_sub_pipe_if.sv
// Operand/result bundle for cla_sub_pipe, valid/ready on both sides.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carried here; master drives operands and out_ready,
// slave (the subtractor) drives in_ready and the result fields.
interface cla_sub_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, zero, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, zero, ovf
  );
endinterface

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead adder slice: s = a + b + ci.
// Latency: 0 cycles (pure logic).
// Backpressure: none. Ports: a, b, ci in; s, co out; p/g are group propagate/generate.
module cla4_slice
  import cla_pkg::*;
(
  input  slice_t a,
  input  slice_t b,
  input  logic   ci,
  output slice_t s,
  output logic   co,
  output logic   p,
  output logic   g
);

  slice_t           pb;  // per-bit propagate
  slice_t           gb;  // per-bit generate
  logic [SLICE_W:0] c;

  assign pb = a ^ b;
  assign gb = a & b;

  // Every internal carry is flattened to a sum of products on ci, so none of
  // them ripples through a neighbouring bit.
  assign c[0] = ci;
  assign c[1] = gb[0] | (pb[0] & ci);
  assign c[2] = gb[1] | (pb[1] & gb[0]) | (pb[1] & pb[0] & ci);
  assign c[3] = gb[2] | (pb[2] & gb[1]) | (pb[2] & pb[1] & gb[0])
              | (pb[2] & pb[1] & pb[0] & ci);

  assign g = gb[3] | (pb[3] & gb[2]) | (pb[3] & pb[2] & gb[1])
           | (pb[3] & pb[2] & pb[1] & gb[0]);
  assign p = &pb;

  assign c[4] = g | (p & ci);
  assign s    = pb ^ c[3:0];
  assign co   = c[4];

endmodule

// File: rtl/cla_sub_pipe.sv
// Pipelined a - b - bin as a + ~b + ~bin, one 4-bit CLA slice per stage.
// Latency: accept on edge N -> out_valid after edge N+STAGES; one result per cycle.
// Backpressure: global stall, in_ready = !out_valid | out_ready; all stages hold together.
// Ports: clk, rst (async, active high); bus = cla_sub_pipe_if.slave (operands, result, flags).
module cla_sub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = SLICE_W
) (
  input logic           clk,
  input logic           rst,
  cla_sub_pipe_if.slave bus
);

  localparam int STAGES = WIDTH / SLICE;

  // Full-width operands travel with each entry; stage k only reads and writes
  // its own slice, so the rest passes forward unchanged.
  typedef struct packed {
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] nb;
    logic             carry;
    logic             zero;
    logic             valid;
  } stage_t;

  // carry resets high so bout (= ~carry) reads 0 out of reset.
  localparam stage_t STAGE_RST = '{diff: '0, a: '0, nb: '0, carry: 1'b1, zero: 1'b0, valid: 1'b0};

  stage_t in_d, in_q;
  stage_t st_in [STAGES];
  stage_t st_d  [STAGES];
  stage_t st_q  [STAGES];

  slice_t            slc_s  [STAGES];
  logic              slc_co [STAGES];
  logic [STAGES-1:0] pg_unused_p;
  logic [STAGES-1:0] pg_unused_g;

  logic adv;

  assign adv          = !st_q[STAGES-1].valid | bus.out_ready;
  assign bus.in_ready = adv;

  // Operands are captured raw so the input path carries no adder logic; the
  // borrow-in becomes the inverted carry-in of slice 0.
  assign in_d = '{diff: '0, a: bus.a, nb: ~bus.b, carry: ~bus.bin, zero: 1'b1, valid: bus.in_valid};

  always_comb begin
    st_in[0] = in_q;
    for (int k = 1; k < STAGES; k++) begin
      st_in[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_slice
    cla4_slice u_cla (
      .a  (st_in[k].a[k*SLICE +: SLICE]),
      .b  (st_in[k].nb[k*SLICE +: SLICE]),
      .ci (st_in[k].carry),
      .s  (slc_s[k]),
      .co (slc_co[k]),
      .p  (pg_unused_p[k]),
      .g  (pg_unused_g[k])
    );
  end

  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      st_d[k]                        = st_in[k];
      st_d[k].diff[k*SLICE +: SLICE] = slc_s[k];
      st_d[k].carry                  = slc_co[k];
      st_d[k].zero                   = st_in[k].zero & (slc_s[k] == '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_q <= STAGE_RST;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= STAGE_RST;
      end
    end else if (adv) begin
      in_q <= in_d;
      for (int k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  assign bus.out_valid = st_q[STAGES-1].valid;
  assign bus.diff      = st_q[STAGES-1].diff;
  assign bus.bout      = ~st_q[STAGES-1].carry;
  assign bus.zero      = st_q[STAGES-1].zero;
  assign bus.ovf       = sub_ovf(st_q[STAGES-1].a[WIDTH-1], st_q[STAGES-1].nb[WIDTH-1],
                                 st_q[STAGES-1].diff[WIDTH-1]);

endmodule

// File: tb/tb_cla_sub_pipe.sv
// Self-checking bench for cla_sub_pipe: directed vectors, streaming, stall and reset.
// Latency: n/a.
// Backpressure: driven from the bench via out_ready.
module tb_cla_sub_pipe;

  typedef struct packed {
    logic [15:0] diff;
    logic        bout;
    logic        zero;
    logic        ovf;
  } exp_t;

  logic clk;
  logic rst;

  cla_sub_pipe_if #(.WIDTH(16)) bus ();

  cla_sub_pipe #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   total = 0;
  int   bad = 0;
  int   n_drained = 0;
  exp_t exp_q [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic bin);
    exp_t e;
    int   r;
    int   sr;
    r      = int'(a) - int'(b) - int'(bin);
    sr     = int'($signed(a)) - int'($signed(b)) - int'(bin);
    e.diff = r[15:0];
    e.bout = (r < 0);
    e.zero = (e.diff == 16'h0);
    e.ovf  = (sr < -32768) || (sr > 32767);
    return e;
  endfunction

  // Scoreboard: handshakes are sampled mid-cycle; they complete on the next rising edge.
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst) begin
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_diff", bus.diff, e.diff);
          chk("sb_bout", bus.bout, e.bout);
          chk("sb_zero", bus.zero, e.zero);
          chk("sb_ovf", bus.ovf, e.ovf);
          n_drained++;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.a, bus.b, bus.bin));
      end
    end
  end

  task automatic drive_rand(input logic vld);
    bus.in_valid = vld;
    bus.a        = 16'($urandom);
    bus.b        = 16'($urandom);
    bus.bin      = 1'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 60; i++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk); #1;
    end
    chk("idle_q", exp_q.size(), 0);
  endtask

  // One operand into an empty pipe; checks latency and the result against constants.
  task automatic send_chk(input logic [15:0] a, input logic [15:0] b, input logic bin, input exp_t want);
    int lat;
    lat = 0;
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.bin      = bin;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
    chk("latency", lat, 4);
    chk("dir_diff", bus.diff, want.diff);
    chk("dir_bout", bus.bout, want.bout);
    chk("dir_zero", bus.zero, want.zero);
    chk("dir_ovf", bus.ovf, want.ovf);
    wait_idle();
  endtask

  initial begin : wdog
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [15:0] ov;
    logic [15:0] snap_diff;
    logic        snap_bout;
    logic        snap_zero;
    logic        snap_ovf;
    int          n0;
    int          q0;

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.bin       = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_diff", bus.diff, 0);
    chk("rst_bout", bus.bout, 0);
    chk("rst_zero", bus.zero, 0);
    chk("rst_ovf", bus.ovf, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_ready", bus.in_ready, 1);

    // Directed vectors
    send_chk(16'h1234, 16'h0234, 1'b0, '{16'h1000, 1'b0, 1'b0, 1'b0});
    send_chk(16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b0});
    send_chk(16'h8000, 16'h0001, 1'b0, '{16'h7FFF, 1'b0, 1'b0, 1'b1});
    send_chk(16'hABCD, 16'hABCD, 1'b0, '{16'h0000, 1'b0, 1'b1, 1'b0});
    send_chk(16'hABCD, 16'hABCC, 1'b1, '{16'h0000, 1'b0, 1'b1, 1'b0});
    send_chk(16'h7FFF, 16'h8000, 1'b0, '{16'hFFFF, 1'b1, 1'b0, 1'b1});

    // Back-to-back stream of 8: results on 8 consecutive cycles, 4 after accept.
    ov = '0;
    for (int t = 0; t < 16; t++) begin
      ov[t] = bus.out_valid;
      drive_rand(t < 8);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    for (int t = 0; t < 16; t++) begin
      chk("stream_vld", ov[t], (t >= 5 && t <= 12) ? 1 : 0);
    end
    wait_idle();

    // Stall with a full pipeline
    bus.out_ready = 1'b0;
    for (int t = 0; t < 8; t++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    snap_diff = bus.diff;
    snap_bout = bus.bout;
    snap_zero = bus.zero;
    snap_ovf  = bus.ovf;
    for (int t = 0; t < 5; t++) begin
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_diff", bus.diff, snap_diff);
      chk("stall_bout", bus.bout, snap_bout);
      chk("stall_zero", bus.zero, snap_zero);
      chk("stall_ovf", bus.ovf, snap_ovf);
      @(posedge clk); #1;
    end
    n0 = n_drained;
    q0 = exp_q.size();
    bus.out_ready = 1'b1;
    #1;
    chk("release_in_ready", bus.in_ready, 1);
    wait_idle();
    chk("stall_drain_cnt", n_drained - n0, q0);

    // Random valid/ready traffic
    for (int t = 0; t < 300; t++) begin
      drive_rand(1'($urandom));
      bus.out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();

    // Reset with 3 operands in flight
    for (int t = 0; t < 3; t++) begin
      drive_rand(1'b1);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_diff", bus.diff, 0);
    chk("mid_rst_bout", bus.bout, 0);
    chk("mid_rst_zero", bus.zero, 0);
    chk("mid_rst_ovf", bus.ovf, 0);
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_in_ready", bus.in_ready, 1);
    n0 = n_drained;
    send_chk(16'h0005, 16'h0003, 1'b0, '{16'h0002, 1'b0, 1'b0, 1'b0});
    repeat (10) @(posedge clk);
    #1;
    chk("post_rst_only_one", n_drained - n0, 1);
    chk("final_q", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_sub_pipe.md
# cla_sub_pipe

Pipelined WIDTH-bit subtractor built from 4-bit carry-lookahead slices. It computes a − b − bin as a + ~b + ~bin, with one 4-bit slice per pipeline stage and the carry registered between stages. The block provides the subtract/compare path for the datapath alongside the existing 4-bit CLA adder. It uses a valid/ready handshake on both sides and full backpressure.

## Interface
- WIDTH, 16: operand width; must be a multiple of SLICE.
- SLICE, 4: bits per stage; fixed to 4, matching the CLA slice.
- STAGES, WIDTH/SLICE: derived value giving the pipeline depth.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  minuend.
- b  in  WIDTH  subtrahend.
- bin  in  1  borrow-in, for chaining.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- diff  out  WIDTH  a − b − bin, mod 2^WIDTH.
- bout  out  1  borrow-out: 1 when a < b + bin (unsigned); equals the inverse of the final carry.
- zero  out  1  diff == 0.
- ovf  out  1  signed overflow: sign(a) ≠ sign(b) and sign(diff) ≠ sign(a).

## Operation
- Global advance: adv = !out_valid | out_ready. in_ready = adv. The whole pipeline shifts only when adv = 1; otherwise every stage holds.
- Accept: an operand is taken when in_valid & in_ready. Stage 0 captures slice 0 of a and ~b, and uses ~bin as carry-in.
- Stage k (0..STAGES-1): computes slice k with the 4-bit CLA.
  - Registers the diff bits, carry-out, the running zero flag (AND of per-slice zero), and the valid bit.
  - Carries the remaining unconsumed operand slices forward unchanged.
- Final stage outputs:
  - bout = ~carry.
  - ovf is computed from the MSBs of a, ~b and diff.
  - zero is the accumulated flag.
- Bubbles (valid = 0) propagate like data and are not compressed.
- Reset (any time, including mid-operation): all valid bits clear to 0 and all in-flight data is discarded.
  - diff, bout, zero and ovf reset to 0.
  - out_valid resets to 0.
  - in_ready = 1 one cycle after reset deassertion (combinational from out_valid = 0).
- Held output: while out_valid & !out_ready, diff, bout, zero and ovf stay stable.
- Arithmetic: WIDTH-bit two's complement. Wrap-around is modulo 2^WIDTH and is not saturated.

## Timing
- Latency: STAGES cycles from acceptance to out_valid, with no stall. With default parameters, an operand accepted on edge N appears on out_valid after edge N+4.
- Throughput: one result per cycle while out_ready = 1.
- Backpressure: out_ready = 0 while out_valid = 1 drops in_ready in the same cycle (combinational path out_ready→in_ready is allowed).
- Simultaneous accept and drain: legal, and the pipeline advances.
- Empty pipeline: out_valid = 0, and adv = 1 regardless of out_ready.
- Inter-stage critical path: one 4-bit CLA slice plus one register.

## Structure
- Shared package cla_pkg holds:
  - constant SLICE_W = 4;
  - typedef slice_t (4-bit);
  - stage record fields: diff bits, carry, zero, valid, remaining a/~b.
- Sub-module cla4_slice: combinational 4-bit CLA with ports a, b, ci → s, co, and group P/G exported for future tree use. It is instantiated STAGES times via generate.
- The top level contains only the stage registers, the adv logic and the output flag logic.

## Test plan
- 0x1234 − 0x0234, bin = 0 → diff 0x1000, bout 0, zero 0, ovf 0, out_valid 4 cycles after accept.
- 0x0000 − 0x0001 → diff 0xFFFF, bout 1, ovf 0. Also 0x8000 − 0x0001 → diff 0x7FFF, bout 0, ovf 1.
- 0xABCD − 0xABCD → diff 0, zero 1. Also 0xABCD − 0xABCC with bin = 1 → diff 0, zero 1, bout 0.
- Back-to-back stream of 8 random pairs with out_ready = 1 → 8 consecutive valid results in order, each matching a − b − bin.
- Hold out_ready = 0 for 5 cycles with a full pipeline → in_ready = 0, outputs stable. On release, results drain in order with no loss or duplication.
- Assert rst with 3 operands in flight → out_valid = 0 and all outputs 0 immediately. A new operand after reset produces only its own result.
